// File: rtl/mobo_bus_bridge.sv
// CPU-to-device bridge: decodes the device from the top address bits and runs a four-phase
// rd/wr-ack handshake with it. Optional handshake abort when MOBO_BRIDGE_TIMEOUT_EN is defined.
module mobo_bus_bridge #(
  parameter int WIDTH    = 32,
  parameter int N_DEV    = 2,
  parameter int SEL_BITS = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic [WIDTH-1:0]       cpu_addr,
  input  logic [WIDTH-1:0]       cpu_wdata,
  output logic [WIDTH-1:0]       cpu_rdata,
  output logic                   cpu_done,
  output logic                   cpu_err,
  output logic                   cpu_busy,
  output logic [N_DEV-1:0]       dev_rd,
  output logic [N_DEV-1:0]       dev_wr,
  input  logic [N_DEV-1:0]       dev_ack,
  output logic [WIDTH-1:0]       dev_addr,
  output logic [WIDTH-1:0]       dev_wdata,
  input  logic [N_DEV*WIDTH-1:0] dev_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_RELEASE, S_DONE, S_ERR
  } state_t;

  localparam logic [WIDTH-1:0] ADDR_MASK = {WIDTH{1'b1}} >> SEL_BITS;

  if (N_DEV < 1 || N_DEV > 16 || SEL_BITS < $clog2(N_DEV) || SEL_BITS >= WIDTH ||
      TIMEOUT < 2) begin : g_bad_params
    $error("mobo_bus_bridge: illegal parameter combination");
  end

  state_t               state_q, state_d;
  logic                 is_rd_q, is_rd_d;
  logic [N_DEV-1:0]     sel_oh_q, sel_oh_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [N_DEV-1:0]     rd_pin_q, rd_pin_d;
  logic [N_DEV-1:0]     wr_pin_q, wr_pin_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q;

  logic [SEL_BITS-1:0]  req_sel;
  logic                 req_mapped;
  logic [N_DEV-1:0]     req_oh;
  logic                 ack_sel;
  logic [WIDTH-1:0]     rdata_mux;
  logic                 tmo;

  assign req_sel    = cpu_addr[WIDTH-1 -: SEL_BITS];
  assign req_mapped = int'(req_sel) < N_DEV;
  assign ack_sel    = |(dev_ack & sel_oh_q);

  always_comb begin
    req_oh    = '0;
    rdata_mux = '0;
    for (int k = 0; k < N_DEV; k++) begin
      req_oh[k] = (int'(req_sel) == k);
      if (sel_oh_q[k]) rdata_mux = rdata_mux | dev_rdata[k*WIDTH +: WIDTH];
    end
  end

`ifdef MOBO_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Zero while idle, so it restarts from 0 on every entry to ISSUE.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_ISSUE || state_q == S_WAIT_ACK || state_q == S_RELEASE)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    is_rd_d  = is_rd_q;
    sel_oh_d = sel_oh_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_pin_d = rd_pin_q;
    wr_pin_d = wr_pin_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((cpu_rd && cpu_wr) || ((cpu_rd || cpu_wr) && !req_mapped)) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (cpu_rd ^ cpu_wr) begin
          state_d  = S_ISSUE;
          is_rd_d  = cpu_rd;
          sel_oh_d = req_oh;
          addr_d   = cpu_addr & ADDR_MASK;
          wdata_d  = cpu_wdata;
        end
      end
      // A still-high ack here belongs to the previous (possibly aborted) transfer.
      S_ISSUE: begin
        if (tmo) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!ack_sel) begin
          state_d = S_WAIT_ACK;
          if (is_rd_q) rd_pin_d = sel_oh_q;
          else         wr_pin_d = sel_oh_q;
        end
      end
      S_WAIT_ACK: begin
        if (tmo) begin
          state_d  = S_ERR;
          done_d   = 1'b1;
          err_d    = 1'b1;
          rd_pin_d = '0;
          wr_pin_d = '0;
        end else if (ack_sel) begin
          state_d  = S_RELEASE;
          rd_pin_d = '0;
          wr_pin_d = '0;
          if (is_rd_q) rdata_d = rdata_mux;
        end
      end
      S_RELEASE: begin
        if (tmo) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!ack_sel) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      is_rd_q  <= 1'b0;
      sel_oh_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_pin_q <= '0;
      wr_pin_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_rd_q  <= is_rd_d;
      sel_oh_q <= sel_oh_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_pin_q <= rd_pin_d;
      wr_pin_q <= wr_pin_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_busy  = busy_q;
  assign dev_rd    = rd_pin_q;
  assign dev_wr    = wr_pin_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_mobo_bus_bridge.sv
// Directed bench for mobo_bus_bridge (N_DEV=2, TIMEOUT=16); a per-vector device model
// answers the handshake with programmable ack rise/fall delays.
module tb_mobo_bus_bridge;
  localparam int W  = 32;
  localparam int ND = 2;
  localparam int SB = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_rd, cpu_wr;
  logic [W-1:0]    cpu_addr, cpu_wdata, cpu_rdata;
  logic            cpu_done, cpu_err, cpu_busy;
  logic [ND-1:0]   dev_rd, dev_wr, dev_ack;
  logic [W-1:0]    dev_addr, dev_wdata;
  logic [ND*W-1:0] dev_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mobo_bus_bridge #(.WIDTH(W), .N_DEV(ND), .SEL_BITS(SB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_ack(dev_ack),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;     // data returned by the target device
    int          pre;     // stale ack of target held for this many cycles
    int          k;       // ack rise delay after pin
    int          j;       // ack fall delay after pin drop
    logic        oth;     // non-selected device holds ack high
    logic        noise;   // CPU drives a second request while busy
    logic        x_err;
    logic [1:0]  x_rdp;
    logic [1:0]  x_wrp;
    logic [31:0] x_rdata;
    int          x_lat;   // edges after the request edge until cpu_done
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    int t, o, done_m, ndone, phase, pcnt, rcnt;
    logic act, addr_ok, wd_ok, oh_ok, busy_ok, busy_after, got_err;
    logic [1:0]  seen_rd, seen_wr;
    logic [31:0] got_rdata, exp_addr;
    t = int'(v.addr[31:28]);
    o = (t == 0) ? 1 : 0;
    act = !v.x_err && (t < ND);
    exp_addr = v.addr & 32'h0FFF_FFFF;
    addr_ok = 1'b1; wd_ok = 1'b1; oh_ok = 1'b1; busy_ok = 1'b1; busy_after = 1'b1;
    got_err = 1'bx; got_rdata = 'x; seen_rd = '0; seen_wr = '0;
    done_m = -1; ndone = 0; phase = 0; pcnt = 0; rcnt = 0;
    @(negedge clk);
    dev_rdata = '0;
    dev_ack   = '0;
    if (act) begin
      dev_rdata[t*W +: W] = v.din;
      dev_rdata[o*W +: W] = ~v.din;
      if (v.oth) dev_ack[o] = 1'b1;
      if (v.pre > 0) dev_ack[t] = 1'b1;
    end
    cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    @(posedge clk); #1;
    if (v.noise) begin
      cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h1000_0000; cpu_wdata = 32'hFFFF_0000;
    end else begin
      cpu_rd = 1'b0; cpu_wr = 1'b0;
    end
    for (int m = 0; m < 60; m++) begin
      @(negedge clk);
      if (cpu_done) begin
        ndone++;
        if (done_m < 0) begin
          done_m = m; got_err = cpu_err; got_rdata = cpu_rdata;
          cpu_rd = 1'b0; cpu_wr = 1'b0;
        end
      end
      if (done_m < 0 || m == done_m) begin
        if (!cpu_busy) busy_ok = 1'b0;
      end else if (m == done_m + 1) begin
        busy_after = cpu_busy;
      end
      seen_rd |= dev_rd;
      seen_wr |= dev_wr;
      if ({dev_rd, dev_wr} != '0 && !$onehot({dev_rd, dev_wr})) oh_ok = 1'b0;
      if ((dev_rd | dev_wr) != '0 || (phase >= 1 && phase <= 3)) begin
        if (dev_addr !== exp_addr) addr_ok = 1'b0;
        if (v.wr && dev_wdata !== v.wdata) wd_ok = 1'b0;
      end
      if (act) begin
        if (v.pre > 0 && m == v.pre) dev_ack[t] = 1'b0;
        if (phase == 0 && (dev_rd[t] || dev_wr[t])) begin phase = 1; pcnt = 0; end
        if (phase == 1) begin
          if (pcnt >= v.k) begin dev_ack[t] = 1'b1; phase = 2; end
          else pcnt++;
        end else if (phase == 2 && !(dev_rd[t] || dev_wr[t])) begin
          phase = 3; rcnt = 0;
        end
        if (phase == 3) begin
          if (rcnt >= v.j) begin dev_ack[t] = 1'b0; phase = 4; end
          else rcnt++;
        end
      end
      if (done_m >= 0 && m >= done_m + 3) break;
    end
    dev_ack = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    chk({tag, "_latency"}, 64'(done_m), 64'(v.x_lat));
    chk({tag, "_err"}, {63'b0, got_err}, {63'b0, v.x_err});
    chk({tag, "_rdata"}, {32'b0, got_rdata}, {32'b0, v.x_rdata});
    chk({tag, "_dev_rd"}, {62'b0, seen_rd}, {62'b0, v.x_rdp});
    chk({tag, "_dev_wr"}, {62'b0, seen_wr}, {62'b0, v.x_wrp});
    chk({tag, "_done_count"}, 64'(ndone), 64'd1);
    chk({tag, "_busy_during"}, {63'b0, busy_ok}, 64'd1);
    chk({tag, "_busy_after"}, {63'b0, busy_after}, 64'd0);
    chk({tag, "_pin_onehot"}, {63'b0, oh_ok}, 64'd1);
    chk({tag, "_dev_addr"}, {63'b0, addr_ok}, 64'd1);
    chk({tag, "_dev_wdata"}, {63'b0, wd_ok}, 64'd1);
  endtask

  task automatic hang_then_reset();
    @(negedge clk);
    cpu_wr = 1'b1; cpu_addr = 32'h1000_0040; cpu_wdata = 32'h0000_0077;
    @(posedge clk); #1 cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("hang_pin", {62'b0, dev_wr}, 64'h2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctl", {57'b0, dev_rd, dev_wr, cpu_done, cpu_err, cpu_busy}, 64'h0);
    chk("async_rst_data", {32'b0, cpu_rdata | dev_addr | dev_wdata}, 64'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {60'b0, cpu_busy, cpu_done, dev_rd[0] | dev_rd[1], dev_wr[0] | dev_wr[1]}, 64'h0);
  endtask

  task automatic no_ack_read(input logic [31:0] exp_rdata);
    int dm, nd;
    logic busy_ok, e_at;
    logic [1:0] pin15, pin_at;
    dm = -1; nd = 0; busy_ok = 1'b1; e_at = 1'bx; pin15 = 'x; pin_at = 'x;
    @(negedge clk);
    dev_ack = '0; cpu_rd = 1'b1; cpu_addr = 32'h0000_0000;
    @(posedge clk); #1 cpu_rd = 1'b0;
`ifdef MOBO_BRIDGE_TIMEOUT_EN
    for (int m = 0; m < 30; m++) begin
      @(negedge clk);
      if (m == 15) pin15 = dev_rd;
      if (cpu_done && dm < 0) begin dm = m; e_at = cpu_err; pin_at = dev_rd | dev_wr; end
      if (cpu_done) nd++;
      if (dm < 0 && !cpu_busy) busy_ok = 1'b0;
    end
    chk("tmo_latency", 64'(dm), 64'(TO));
    chk("tmo_err", {63'b0, e_at}, 64'd1);
    chk("tmo_pin_before", {62'b0, pin15}, 64'h1);
    chk("tmo_pin_after", {62'b0, pin_at}, 64'h0);
    chk("tmo_done_count", 64'(nd), 64'd1);
    chk("tmo_busy", {63'b0, busy_ok}, 64'd1);
    chk("tmo_rdata", {32'b0, cpu_rdata}, {32'b0, exp_rdata});
`else
    for (int m = 0; m < 120; m++) begin
      @(negedge clk);
      if (cpu_done) nd++;
      if (!cpu_busy) busy_ok = 1'b0;
    end
    pin_at = dev_rd;
    chk("noto_busy", {63'b0, busy_ok}, 64'd1);
    chk("noto_done_count", 64'(nd), 64'd0);
    chk("noto_pin_held", {62'b0, pin_at}, 64'h1);
    chk("noto_rdata", {32'b0, cpu_rdata}, {32'b0, exp_rdata});
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("noto_rst_busy", {63'b0, cpu_busy}, 64'd0);
`endif
  endtask

  initial begin
    vec_t fr;
    tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_0001, 32'h0, 0, 2, 1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 32'h0, 6};
    tbl[1] = '{1'b1, 1'b0, 32'h1000_0004, 32'h0, 32'h0000_0241, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 32'h241, 3};
    tbl[2] = '{1'b1, 1'b0, 32'h7000_0000, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h241, 0};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h241, 0};
    tbl[4] = '{1'b0, 1'b1, 32'h1ABC_DEF0, 32'h1234_5678, 32'h0, 0, 1, 2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 32'h241, 6};
    tbl[5] = '{1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0, 32'hDEAD_BEEF, 0, 3, 0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 32'hDEAD_BEEF, 6};
    tbl[6] = '{1'b0, 1'b1, 32'hF000_0000, 32'h1, 32'h0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'hDEAD_BEEF, 0};
    tbl[7] = '{1'b1, 1'b0, 32'h1000_0000, 32'h0, 32'h0000_A5A5, 0, 4, 3, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 32'h0000_A5A5, 10};
    tbl[8] = '{1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 32'h0, 2, 1, 1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 32'h0000_A5A5, 7};
    tbl[9] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1357_9BDF, 0, 2, 2, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 32'h1357_9BDF, 7};
    fr     = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h0F0F_1234, 0, 1, 1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h0F0F_1234, 5};

    rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_ack = '0; dev_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {57'b0, dev_rd, dev_wr, cpu_done, cpu_err, cpu_busy}, 64'h0);
    chk("reset_data", {32'b0, cpu_rdata | dev_addr | dev_wdata}, 64'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

    hang_then_reset();
    do_txn("fresh_rd", fr);
    no_ack_read(32'h0F0F_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
